// File: rtl/store_narrow_unit.sv
// Narrows a 32-bit register value to word/halfword/byte and stores it into
// word-wide memory without byte enables, using read-modify-write for sub-words.
module store_narrow_unit #(
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic [1:0]        StoreSel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;

    localparam logic [1:0] SEL_W    = 2'b00;
    localparam logic [1:0] SEL_H    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [1:0]        sel_q, sel_d;
    logic [31:0]       merge_q, merge_d;
    logic [1:0]        cnt_q, cnt_d;

    logic [1:0]  sel_in;
    logic        misaligned;
    logic [31:0] merged;

    assign sel_in     = (StoreSel == 2'b11) ? SEL_W : StoreSel;
    assign misaligned = ((sel_in == SEL_W) && (addr[1:0] != 2'b00)) ||
                        ((sel_in == SEL_H) && addr[0]);

    // Little-endian lane insert of the latched data into the word just read.
    always_comb begin
        merged = mem_rdata;
        if (sel_q == SEL_B)
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else if (sel_q == SEL_H)
            merged[{addr_q[1], 4'b0000} +: 16] = data_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        merge_d = merge_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = addr;
                    data_d = wdata[15:0];
                    sel_d  = sel_in;
                    if (misaligned) begin
                        state_d = ERR;
                    end else if (sel_in == SEL_W) begin
                        merge_d = wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    merge_d = merged;
                    state_d = WRITE;
                end
            end
            WRITE:     state_d = DONE;
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            merge_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            merge_q <= merge_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs depend only on flops, so reset clears them without a clock.
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) || (state_q == ERR);
    assign err       = (state_q == ERR);
    assign mem_rd    = (state_q == READ);
    assign mem_wr    = (state_q == WRITE);
    assign mem_wdata = (state_q == WRITE) ? merge_q : 32'h0;
    assign mem_addr  = ((state_q == READ) || (state_q == WAIT) || (state_q == WRITE)) ?
                       {addr_q[ADDR_W-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench: two instances (read latency 1 and 3) share stimulus and a
// behavioural memory that only presents valid read data in the right cycle.
module tb_store_narrow_unit;

    logic CLK = 1'b0;
    logic Reset = 1'b0;
    always #5 CLK = ~CLK;

    logic [1:0]  start;
    logic [1:0]  StoreSel;
    logic [31:0] addr, wdata;
    logic [1:0]  busy, done, err, mem_rd, mem_wr;
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] mem [256];
    logic [3:0]  rd_sh0 = '0;
    logic [3:0]  rd_sh1 = '0;
    longint      cyc = 0;

    typedef struct {
        int          d;
        longint      cyc;
        logic [31:0] a;
        logic [31:0] v;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t dn_q[$];
    int  errors = 0;
    int  checks = 0;

    always @(posedge CLK) begin
        cyc    <= cyc + 1;
        rd_sh0 <= {rd_sh0[2:0], mem_rd[0]};
        rd_sh1 <= {rd_sh1[2:0], mem_rd[1]};
    end

    // Read data is garbage except in the cycle RD_LATENCY after mem_rd.
    assign mem_rdata[0] = rd_sh0[0] ? mem[mem_addr[0][9:2]] : 32'hA5A5A5A5;
    assign mem_rdata[1] = rd_sh1[2] ? mem[mem_addr[1][9:2]] : 32'hA5A5A5A5;

    store_narrow_unit #(.ADDR_W(32), .RD_LATENCY(1)) dut1 (
        .CLK(CLK), .Reset(Reset), .start(start[0]), .StoreSel(StoreSel),
        .addr(addr), .wdata(wdata), .busy(busy[0]), .done(done[0]), .err(err[0]),
        .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata[0]),
        .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]));

    store_narrow_unit #(.ADDR_W(32), .RD_LATENCY(3)) dut3 (
        .CLK(CLK), .Reset(Reset), .start(start[1]), .StoreSel(StoreSel),
        .addr(addr), .wdata(wdata), .busy(busy[1]), .done(done[1]), .err(err[1]),
        .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata[1]),
        .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] old, input logic [1:0] sel,
                                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r;
        int base, n;
        r = old;
        if (sel == 2'd2) begin base = int'(a[1:0]); n = 1; end
        else if (sel == 2'd1) begin base = a[1] ? 2 : 0; n = 2; end
        else begin base = 0; n = 4; end
        for (int i = 0; i < n; i++) r[(base + i) * 8 +: 8] = wd[i * 8 +: 8];
        return r;
    endfunction

    task automatic monitor();
        ev_t    e;
        longint obs;
        forever begin
            @(negedge CLK);
            obs = cyc + 1;
            for (int d = 0; d < 2; d++) begin
                if (mem_rd[d]) begin
                    if (rd_q.size() > 0 && rd_q[0].d == d) begin
                        e = rd_q.pop_front();
                        chk("rd_cyc", 64'(obs), 64'(e.cyc));
                        chk("rd_addr", 64'(mem_addr[d]), 64'(e.a));
                    end else chk("rd_unexp", 64'(mem_rd[d]), 64'd0);
                end
                if (mem_wr[d]) begin
                    if (wr_q.size() > 0 && wr_q[0].d == d) begin
                        e = wr_q.pop_front();
                        chk("wr_cyc", 64'(obs), 64'(e.cyc));
                        chk("wr_addr", 64'(mem_addr[d]), 64'(e.a));
                        chk("wr_data", 64'(mem_wdata[d]), 64'(e.v));
                    end else chk("wr_unexp", 64'(mem_wr[d]), 64'd0);
                    mem[mem_addr[d][9:2]] = mem_wdata[d];
                end else chk("wdata_idle", 64'(mem_wdata[d]), 64'd0);
                if (done[d]) begin
                    if (dn_q.size() > 0 && dn_q[0].d == d) begin
                        e = dn_q.pop_front();
                        chk("done_cyc", 64'(obs), 64'(e.cyc));
                        chk("err", 64'(err[d]), 64'(e.v[0]));
                    end else chk("done_unexp", 64'(done[d]), 64'd0);
                end else chk("err_nodone", 64'(err[d]), 64'd0);
                if (!busy[d]) chk("addr_idle", 64'(mem_addr[d]), 64'd0);
            end
        end
    endtask

    // Drives a one-cycle start in the current cycle (edge k samples it).
    task automatic issue(input int d, input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] expv);
        longint k;
        longint lat;
        logic   isw, mis;
        lat = (d == 1) ? 3 : 1;
        k   = cyc + 1;
        isw = (sel == 2'd0) || (sel == 2'd3);
        mis = (isw && a[1:0] != 2'b00) || (sel == 2'd1 && a[0]);
        StoreSel = sel; addr = a; wdata = wd; start[d] = 1'b1;
        if (mis) begin
            dn_q.push_back('{d, k + 1, 32'h0, 32'h1});
        end else if (isw) begin
            wr_q.push_back('{d, k + 1, {a[31:2], 2'b00}, expv});
            dn_q.push_back('{d, k + 2, 32'h0, 32'h0});
        end else begin
            rd_q.push_back('{d, k + 1, {a[31:2], 2'b00}, 32'h0});
            wr_q.push_back('{d, k + 2 + lat, {a[31:2], 2'b00}, expv});
            dn_q.push_back('{d, k + 3 + lat, 32'h0, 32'h0});
        end
        @(posedge CLK); #1;
        start[d] = 1'b0;
        StoreSel = 2'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rd_q.size() + wr_q.size() + dn_q.size()) != 0 && n < 60) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 60) begin
            chk("timeout", 64'(dn_q.size() + wr_q.size() + rd_q.size()), 64'd0);
            rd_q.delete(); wr_q.delete(); dn_q.delete();
        end
        repeat (4) begin @(posedge CLK); #1; end
    endtask

    initial begin
        logic [31:0] a, wd, old;
        logic [1:0]  sel;
        int          d;
        start = '0; StoreSel = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        fork monitor(); join_none
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 64'(busy[i]), 64'd0);
            chk("rst_done", 64'(done[i]), 64'd0);
            chk("rst_wr", 64'(mem_wr[i]), 64'd0);
            chk("rst_rd", 64'(mem_rd[i]), 64'd0);
            chk("rst_addr", 64'(mem_addr[i]), 64'd0);
        end
        Reset = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end

        issue(0, 2'd0, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF); wait_idle();
        mem[8'h80] = 32'h11223344;
        issue(0, 2'd2, 32'h202, 32'hFFFFFFAB, 32'h11AB3344); wait_idle();
        mem[8'h81] = 32'h11223344;
        issue(0, 2'd1, 32'h206, 32'h0000BEEF, 32'hBEEF3344); wait_idle();
        mem[8'h81] = 32'h11223344;
        issue(0, 2'd1, 32'h204, 32'h0000BEEF, 32'h1122BEEF); wait_idle();
        issue(0, 2'd3, 32'h10C, 32'h01234567, 32'h01234567); wait_idle();

        // Misaligned pair, then a word store the cycle after the second done.
        issue(0, 2'd0, 32'h101, 32'h12345678, 32'h0);
        @(posedge CLK); #1;
        issue(0, 2'd1, 32'h203, 32'h12345678, 32'h0);
        @(posedge CLK); #1;
        issue(0, 2'd0, 32'h108, 32'hCAFEF00D, 32'hCAFEF00D); wait_idle();

        // Start coinciding with done must be ignored.
        issue(0, 2'd0, 32'h110, 32'h0BADF00D, 32'h0BADF00D);
        @(posedge CLK); #1;
        start[0] = 1'b1; StoreSel = 2'd0; addr = 32'h114;
        @(posedge CLK); #1;
        start[0] = 1'b0;
        wait_idle();

        // Latency 3 byte store with a start pulse while busy.
        mem[8'hC0] = 32'h55667788;
        issue(1, 2'd2, 32'h300, 32'h000000EE, 32'h556677EE);
        start[1] = 1'b1; StoreSel = 2'd0; addr = 32'h304;
        @(posedge CLK); #1;
        start[1] = 1'b0;
        wait_idle();

        // Reset in WAIT abandons the store.
        mem[8'hC1] = 32'h99887766;
        issue(1, 2'd2, 32'h305, 32'h00000011, 32'h99881166);
        @(posedge CLK); #1;
        Reset = 1'b0;
        #1;
        chk("rstw_busy", 64'(busy[1]), 64'd0);
        chk("rstw_rd", 64'(mem_rd[1]), 64'd0);
        chk("rstw_wr", 64'(mem_wr[1]), 64'd0);
        rd_q.delete(); wr_q.delete(); dn_q.delete();
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b1;
        repeat (8) begin @(posedge CLK); #1; end
        chk("rstw_mem", 64'(mem[8'hC1]), 64'h99887766);
        mem[8'hC1] = 32'h99887766;
        issue(1, 2'd1, 32'h306, 32'h0000ABCD, 32'hABCD7766); wait_idle();

        for (int t = 0; t < 10; t++) begin
            d   = int'($urandom_range(0, 1));
            sel = 2'($urandom);
            a   = 32'($urandom_range(0, 1023));
            wd  = $urandom;
            old = $urandom;
            mem[a[9:2]] = old;
            issue(d, sel, a, wd, model(old, sel, a, wd));
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
